// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen
// Quadrature encoder emitter. Turns a valid/ready stream of step commands
// into an x4 Gray-coded chA/chB pair. Output transitions are spaced by a
// programmable minimum number of clocks. A position count bounded to
// 0..POS_MAX is maintained alongside the outputs.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous, active-high reset
//   step_valid   step command present
//   step_dir     1 = up (chA leads chB), 0 = down (chB leads chA)
//   step_ready   a step can be accepted this cycle (registered hold state only)
//   phase_ticks  minimum clocks between transitions, 0 behaves as 1
//   chA, chB     quadrature outputs, registered
//   position     current position, 0..POS_MAX
//   limit        one-cycle pulse when an accepted step hits a bound
module quad_encoder_gen #(
    parameter int POS_W   = 11,
    parameter int POS_MAX = 1000,
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_valid,
    input  logic               step_dir,
    output logic               step_ready,
    input  logic [PHASE_W-1:0] phase_ticks,
    output logic               chA,
    output logic               chB,
    output logic [POS_W-1:0]   position,
    output logic               limit
);

    localparam logic [POS_W-1:0] POS_TOP = POS_W'(POS_MAX);

    logic [PHASE_W-1:0] cnt;
    logic [PHASE_W-1:0] hold_len;
    logic               accept;
    logic               at_bound;
    logic               move;
    logic [1:0]         q_next;

    // Ready comes only from the hold counter, so valid never loops back into it.
    assign step_ready = (cnt == '0);
    assign accept     = step_valid && step_ready;

    // Load N-1 with N = max(phase_ticks,1); a zero setting gives back-to-back steps.
    assign hold_len = (phase_ticks == '0) ? '0 : phase_ticks - PHASE_W'(1);

    // A step at a bound still completes the handshake and loads the hold;
    // it just does not move the outputs.
    assign at_bound = step_dir ? (position == POS_TOP) : (position == '0);
    assign move     = accept && !at_bound;

    // Gray sequence. Up: 00->10->11->01->00, down is the reverse.
    always_comb begin
        q_next = {chA, chB};
        if (step_dir) begin
            case ({chA, chB})
                2'b00:   q_next = 2'b10;
                2'b10:   q_next = 2'b11;
                2'b11:   q_next = 2'b01;
                default: q_next = 2'b00;
            endcase
        end else begin
            case ({chA, chB})
                2'b00:   q_next = 2'b01;
                2'b01:   q_next = 2'b11;
                2'b11:   q_next = 2'b10;
                default: q_next = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= hold_len;
        end else if (cnt != '0) begin
            cnt <= cnt - PHASE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chA      <= 1'b0;
            chB      <= 1'b0;
            position <= '0;
            limit    <= 1'b0;
        end else begin
            limit <= accept && at_bound;
            if (move) begin
                {chA, chB} <= q_next;
                position   <= step_dir ? position + POS_W'(1)
                                       : position - POS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: directed vectors, a position-based reference
// model compared every cycle, and hand-computed literal checks.
module tb_quad_encoder_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_valid = 1'b0;
    logic        step_dir = 1'b0;
    logic        step_ready;
    logic [15:0] phase_ticks = 16'd1;
    logic        chA, chB;
    logic [10:0] position;
    logic        limit;

    int vectors = 0;
    int miscompares = 0;

    quad_encoder_gen #(.POS_W(11), .POS_MAX(1000), .PHASE_W(16)) dut (
        .clk(clk), .rst(rst), .step_valid(step_valid), .step_dir(step_dir),
        .step_ready(step_ready), .phase_ticks(phase_ticks), .chA(chA), .chB(chB),
        .position(position), .limit(limit)
    );

    always #5 clk = ~clk;

    // Reference model: the quadrature state is a pure function of position
    // (both start at zero and always move together), and readiness is a
    // matter of how many edges have passed since the last acceptance.
    int m_pos, m_last, m_n, m_cyc;
    bit m_lim, m_free;

    function automatic logic [1:0] gray_of(input int p);
        logic [1:0] tbl [4];
        tbl[0] = 2'b00; tbl[1] = 2'b10; tbl[2] = 2'b11; tbl[3] = 2'b01;
        return tbl[p % 4];
    endfunction

    function automatic bit m_ready();
        return m_free || (m_cyc >= m_last + m_n);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos <= 0; m_lim <= 0; m_free <= 1; m_cyc <= 0; m_last <= 0; m_n <= 1;
        end else begin
            if (step_valid && m_ready()) begin
                m_last <= m_cyc;
                m_n    <= (phase_ticks == 0) ? 1 : int'(phase_ticks);
                m_free <= 0;
                if (step_dir && m_pos < 1000) begin
                    m_pos <= m_pos + 1; m_lim <= 0;
                end else if (!step_dir && m_pos > 0) begin
                    m_pos <= m_pos - 1; m_lim <= 0;
                end else begin
                    m_lim <= 1;
                end
            end else begin
                m_lim <= 0;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if ({chA, chB} !== gray_of(m_pos) || position !== 11'(m_pos) ||
                limit !== m_lim || step_ready !== m_ready()) begin
                miscompares++;
                $display("FAIL model t=%0t: got ab=%b pos=%0d lim=%b rdy=%b, want ab=%b pos=%0d lim=%b rdy=%b",
                         $time, {chA, chB}, position, limit, step_ready,
                         gray_of(m_pos), m_pos, m_lim, m_ready());
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; holds the inputs for n full cycles.
    task automatic drive(input logic v, input logic d, input int pt, input int n);
        step_valid  = v;
        step_dir    = d;
        phase_ticks = pt[15:0];
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        step_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("reset_ab", {chA, chB}, 0);
        chk("reset_pos", position, 0);
        chk("reset_rdy", step_ready, 1);
        chk("reset_lim", limit, 0);

        // Four up steps, phase_ticks=4, valid held high.
        drive(1, 1, 4, 1);
        chk("up4_first_ab", {chA, chB}, 2);
        chk("up4_first_rdy", step_ready, 0);
        drive(1, 1, 4, 12);
        chk("up4_ab", {chA, chB}, 0);
        chk("up4_pos", position, 4);
        drive(0, 1, 4, 3);

        // Down from reset hits the lower bound.
        do_reset();
        drive(1, 0, 4, 1);
        chk("low_lim", limit, 1);
        chk("low_ab", {chA, chB}, 0);
        chk("low_pos", position, 0);
        chk("low_rdy", step_ready, 0);
        drive(0, 0, 4, 1);
        chk("low_lim_pulse", limit, 0);
        drive(0, 0, 4, 2);
        chk("low_rdy_back", step_ready, 1);
        drive(1, 1, 4, 1);
        chk("low_up_ab", {chA, chB}, 2);
        chk("low_up_pos", position, 1);
        drive(0, 1, 4, 3);

        // phase_ticks 0 and 1: one transition per clock.
        do_reset();
        drive(1, 1, 0, 3);
        chk("pt0_pos", position, 3);
        chk("pt0_ab", {chA, chB}, 1);
        chk("pt0_rdy", step_ready, 1);
        drive(1, 1, 1, 3);
        chk("pt1_pos", position, 6);
        chk("pt1_ab", {chA, chB}, 3);

        // Run to the upper bound and back off by one.
        do_reset();
        drive(1, 1, 1, 1000);
        chk("top_pos", position, 1000);
        chk("top_ab", {chA, chB}, 0);
        drive(1, 1, 1, 1);
        chk("top_lim", limit, 1);
        chk("top_pos_hold", position, 1000);
        chk("top_ab_hold", {chA, chB}, 0);
        drive(1, 0, 1, 1);
        chk("top_down_pos", position, 999);
        chk("top_down_ab", {chA, chB}, 1);
        chk("top_down_lim", limit, 0);

        // Up, up, down, down with phase_ticks changed mid-hold.
        do_reset();
        drive(1, 1, 2, 1);
        chk("mix_s1_ab", {chA, chB}, 2);
        drive(1, 1, 6, 1);
        chk("mix_old_hold", step_ready, 1);
        drive(1, 1, 6, 1);
        chk("mix_s2_ab", {chA, chB}, 3);
        chk("mix_s2_pos", position, 2);
        drive(1, 0, 2, 4);
        chk("mix_hold6", step_ready, 0);
        drive(1, 0, 2, 1);
        chk("mix_hold6_end", step_ready, 1);
        drive(1, 0, 2, 1);
        chk("mix_s3_ab", {chA, chB}, 2);
        chk("mix_s3_pos", position, 1);
        drive(1, 0, 2, 2);
        chk("mix_s4_ab", {chA, chB}, 0);
        chk("mix_s4_pos", position, 0);
        drive(0, 0, 2, 2);

        // Reset in the middle of the third hold.
        do_reset();
        drive(1, 1, 8, 17);
        chk("mid_pos", position, 3);
        drive(1, 1, 8, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_ab", {chA, chB}, 0);
        chk("mid_rst_pos", position, 0);
        chk("mid_rst_rdy", step_ready, 1);
        chk("mid_rst_lim", limit, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 8, 1);
        chk("mid_after_ab", {chA, chB}, 2);
        chk("mid_after_pos", position, 1);
        drive(0, 1, 8, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
